// File: rtl/ram_master_pkg.sv
// ram_master_pkg
// Shared definitions for the RAM initiator and its helpers.
//   - FSM state encoding (2-bit constants)
//   - RAM strobe polarity (RW_READ / RW_WRITE)
//   - bus-release value for the shared tristate data bus
//   - width of the wait-state counter and a helper to form its load value
package ram_master_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_WRITE = 2'd1;
    localparam state_t ST_READ  = 2'd2;
    localparam state_t ST_DONE  = 2'd3;

    localparam logic RW_READ  = 1'b1;
    localparam logic RW_WRITE = 1'b0;

    // Replicated across the data width wherever the master lets go of the bus.
    localparam logic BUS_RELEASE = 1'bz;

    localparam int WAIT_W = 8;

    // The counter is loaded with read_wait - 1 on the accepting edge, so the
    // capture edge lands read_wait edges after the accept.
    function automatic logic [WAIT_W-1:0] wait_load(input int read_wait);
        return WAIT_W'(read_wait - 1);
    endfunction

endpackage

// File: rtl/ram_master_if.sv
// ram_master_if
// Cache-side request/completion channel of the RAM initiator.
//   req        : request strobe, only looked at while the master is idle
//   req_rw     : 1 = read, 0 = write
//   req_addr   : word address
//   req_wdata  : write data
//   busy       : master is handling an access
//   done       : one-cycle completion pulse
//   rdata      : last read result, held until the next read completes
//   state_dbg  : current FSM state, for observation only
// Handshake: a request is taken on any rising edge where req = 1 and busy = 0;
// the requester learns of completion from a single-cycle done pulse, and a
// req raised while busy = 1 is dropped, not queued.
interface ram_master_if #(
    parameter int AW = 8,
    parameter int DW = 8
);
    import ram_master_pkg::*;

    logic          req;
    logic          req_rw;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata;
    logic          busy;
    logic          done;
    logic [DW-1:0] rdata;
    state_t        state_dbg;

    modport master (
        output req, req_rw, req_addr, req_wdata,
        input  busy, done, rdata, state_dbg
    );

    modport slave (
        input  req, req_rw, req_addr, req_wdata,
        output busy, done, rdata, state_dbg
    );

endinterface

// File: rtl/ram_master_wait_counter.sv
// wait_counter
// Loadable 8-bit down-counter used to time RAM wait states.
//   clk      : posedge clock
//   clr      : asynchronous active-low reset (count returns to 0)
//   load     : load load_val on the next edge (wins over dec)
//   load_val : value to load
//   dec      : decrement on the next edge; ignored once the count is 0
//   zero     : count is 0
module wait_counter
    import ram_master_pkg::*;
(
    input  logic              clk,
    input  logic              clr,
    input  logic              load,
    input  logic [WAIT_W-1:0] load_val,
    input  logic              dec,
    output logic              zero
);

    logic [WAIT_W-1:0] count_q;
    logic [WAIT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (dec && (count_q != '0)) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign zero = (count_q == '0);

endmodule

// File: rtl/ram_master.sv
// ram_master
// Initiator-side controller for the register RAM. Takes single-word read or
// write requests from the cache and runs them on the RAM bus, stretching
// reads by a fixed number of wait states.
//   clk       : posedge clock
//   clr       : asynchronous active-low reset
//   req_if    : cache request/completion channel (slave side)
//   ram_addr  : RAM address (latched request address, verbatim)
//   ram_ce    : RAM chip enable
//   ram_rw    : RAM strobe, 1 = read, 0 = write
//   ram_data  : shared RAM data bus; driven only during the write cycle
module ram_master
    import ram_master_pkg::*;
#(
    parameter int d_width   = 8,
    parameter int a_width   = 8,
    parameter int read_wait = 4
) (
    input  logic               clk,
    input  logic               clr,
    ram_master_if.slave        req_if,
    output logic [a_width-1:0] ram_addr,
    output logic               ram_ce,
    output logic               ram_rw,
    inout  wire  [d_width-1:0] ram_data
);

    localparam logic [WAIT_W-1:0] WAIT_LOAD = wait_load(read_wait);

    state_t               state_q, state_d;
    logic [a_width-1:0]   addr_q,  addr_d;
    logic                 ce_q,    ce_d;
    logic                 rw_q,    rw_d;
    logic [d_width-1:0]   wdata_q, wdata_d;
    logic [d_width-1:0]   rdata_q, rdata_d;
    logic                 done_q,  done_d;
    logic                 busy_q,  busy_d;

    logic                 cnt_load;
    logic                 cnt_dec;
    logic                 cnt_zero;

    wait_counter u_wait (
        .clk      (clk),
        .clr      (clr),
        .load     (cnt_load),
        .load_val (WAIT_LOAD),
        .dec      (cnt_dec),
        .zero     (cnt_zero)
    );

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        ce_d     = ce_q;
        rw_d     = rw_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        done_d   = 1'b0;
        cnt_load = 1'b0;
        cnt_dec  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (req_if.req) begin
                    addr_d  = req_if.req_addr;
                    wdata_d = req_if.req_wdata;
                    ce_d    = 1'b1;
                    if (req_if.req_rw == RW_READ) begin
                        rw_d     = RW_READ;
                        cnt_load = 1'b1;
                        state_d  = ST_READ;
                    end else begin
                        rw_d    = RW_WRITE;
                        state_d = ST_WRITE;
                    end
                end
            end
            ST_WRITE: begin
                // The RAM stores the word on this closing edge.
                ce_d    = 1'b0;
                rw_d    = RW_READ;
                done_d  = 1'b1;
                state_d = ST_DONE;
            end
            ST_READ: begin
                if (!cnt_zero) begin
                    cnt_dec = 1'b1;
                end else begin
                    // The RAM output register has been valid since the first
                    // READ edge; ce is still high here so the bus is driven.
                    rdata_d = ram_data;
                    ce_d    = 1'b0;
                    done_d  = 1'b1;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                ce_d    = 1'b0;
                rw_d    = RW_READ;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            ce_q    <= 1'b0;
            rw_q    <= RW_READ;
            wdata_q <= '0;
            rdata_q <= '0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            ce_q    <= ce_d;
            rw_q    <= rw_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
        end
    end

    // Only the write cycle owns the bus; there ram_rw = 0 keeps the RAM's
    // output buffer off, so the two ends never drive together.
    assign ram_data = (state_q == ST_WRITE) ? wdata_q : {d_width{BUS_RELEASE}};

    assign ram_addr         = addr_q;
    assign ram_ce           = ce_q;
    assign ram_rw           = rw_q;
    assign req_if.busy      = busy_q;
    assign req_if.done      = done_q;
    assign req_if.rdata     = rdata_q;
    assign req_if.state_dbg = state_q;

endmodule

// File: tb/tb_ram_master.sv
// tb_ram_master
// Two ram_master instances (read_wait = 4 and read_wait = 2) share one
// request stream; each has its own RAM model on its bus. A reference model
// decides from the documented timing rules which requests each instance
// accepts, predicts completion edge and read data, and a negedge monitor
// checks bus activity, busy, done and rdata against those predictions.
module tb_ram_master;

    localparam int DW  = 8;
    localparam int AW  = 8;
    localparam int RW0 = 4;
    localparam int RW1 = 2;

    logic       clk = 1'b0;
    logic       clr = 1'b1;
    logic       req = 1'b0;
    logic       req_rw = 1'b0;
    logic [7:0] req_addr = 8'h00;
    logic [7:0] req_wdata = 8'h00;

    always #5 clk = ~clk;

    logic [7:0] ram_addr_w [2];
    logic       ram_ce_w   [2];
    logic       ram_rw_w   [2];
    logic [7:0] bus_w      [2];
    logic       busy_w     [2];
    logic       done_w     [2];
    logic [7:0] rdata_w    [2];

    function automatic logic [7:0] init_word(input int k, input int i);
        if (i == 8'h80) return 8'h5A;
        return 8'((i * 37 + 11 + k * 5) & 255);
    endfunction

    // ---------------- DUTs and RAM models ----------------
    for (genvar k = 0; k < 2; k++) begin : g_inst
        localparam int RWAIT = (k == 0) ? RW0 : RW1;

        ram_master_if #(.AW(AW), .DW(DW)) bus_if ();

        wire  [7:0] ram_data;
        logic [7:0] ram_addr;
        logic       ram_ce;
        logic       ram_rw;
        logic [7:0] ram_mem [256];
        logic [7:0] ram_dout;

        assign bus_if.req       = req;
        assign bus_if.req_rw    = req_rw;
        assign bus_if.req_addr  = req_addr;
        assign bus_if.req_wdata = req_wdata;

        ram_master #(
            .d_width   (DW),
            .a_width   (AW),
            .read_wait (RWAIT)
        ) u_dut (
            .clk      (clk),
            .clr      (clr),
            .req_if   (bus_if.slave),
            .ram_addr (ram_addr),
            .ram_ce   (ram_ce),
            .ram_rw   (ram_rw),
            .ram_data (ram_data)
        );

        initial begin
            for (int i = 0; i < 256; i++) ram_mem[i] = init_word(k, i);
            ram_dout = 8'h00;
        end

        // Synchronous RAM with a registered read port.
        always @(posedge clk) begin
            if (ram_ce && !ram_rw) ram_mem[ram_addr] <= ram_data;
            if (ram_ce && ram_rw)  ram_dout <= ram_mem[ram_addr];
        end

        assign ram_data = (ram_ce && ram_rw) ? ram_dout : 8'bz;

        assign ram_addr_w[k] = ram_addr;
        assign ram_ce_w[k]   = ram_ce;
        assign ram_rw_w[k]   = ram_rw;
        assign bus_w[k]      = ram_data;
        assign busy_w[k]     = bus_if.busy;
        assign done_w[k]     = bus_if.done;
        assign rdata_w[k]    = bus_if.rdata;
    end

    // ---------------- reference model ----------------
    int         checks = 0;
    int         failures = 0;
    int         edge_cnt = 0;
    int         rwait [2] = '{RW0, RW1};
    int         nf [2] = '{0, 0};        // first edge at which a new req is taken
    bit         cur_valid [2] = '{0, 0};
    int         cur_acc [2] = '{0, 0};
    bit         cur_read [2];
    logic [7:0] cur_addr [2];
    logic [7:0] cur_wdata [2];
    logic [7:0] last_rd [2] = '{8'h00, 8'h00};
    logic [7:0] mdl_mem [2][256];
    logic [39:0] exp_q [2][$];          // {done edge, rdata}

    initial begin
        for (int k = 0; k < 2; k++)
            for (int i = 0; i < 256; i++) mdl_mem[k][i] = init_word(k, i);
    end

    always @(posedge clk) begin
        edge_cnt++;
        if (clr) begin
            for (int k = 0; k < 2; k++) begin
                if (req && edge_cnt >= nf[k]) begin
                    cur_valid[k] = 1'b1;
                    cur_acc[k]   = edge_cnt;
                    cur_read[k]  = req_rw;
                    cur_addr[k]  = req_addr;
                    cur_wdata[k] = req_wdata;
                    if (req_rw) begin
                        last_rd[k] = mdl_mem[k][req_addr];
                        exp_q[k].push_back({32'(edge_cnt + rwait[k]), last_rd[k]});
                        nf[k] = edge_cnt + rwait[k] + 2;
                    end else begin
                        mdl_mem[k][req_addr] = req_wdata;
                        exp_q[k].push_back({32'(edge_cnt + 1), last_rd[k]});
                        nf[k] = edge_cnt + 3;
                    end
                end
            end
        end
    end

    task automatic chk(input string name, input int k, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s[%0d] at edge %0d: got %0h expected %0h",
                     name, k, edge_cnt, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            cur_valid[k] = 1'b0;
            nf[k]        = 0;
            last_rd[k]   = 8'h00;
            exp_q[k].delete();
        end
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (clr) begin
            for (int k = 0; k < 2; k++) begin
                int  e;
                int  last_ce;
                int  lat;
                bit  in_acc;
                bit  busy_exp;
                e       = edge_cnt;
                lat     = cur_read[k] ? rwait[k] : 1;
                last_ce = cur_read[k] ? cur_acc[k] + rwait[k] - 1 : cur_acc[k];
                in_acc  = cur_valid[k] && e >= cur_acc[k] && e <= last_ce;
                busy_exp = cur_valid[k] && e >= cur_acc[k] && e <= cur_acc[k] + lat;

                chk("ram_ce", k, 32'(ram_ce_w[k]), 32'(in_acc));
                chk("busy", k, 32'(busy_w[k]), 32'(busy_exp));
                if (in_acc) begin
                    chk("ram_rw", k, 32'(ram_rw_w[k]), 32'(cur_read[k]));
                    chk("ram_addr", k, 32'(ram_addr_w[k]), 32'(cur_addr[k]));
                    checks++;
                    if ($isunknown(bus_w[k])) begin
                        failures++;
                        $display("FAIL bus_x[%0d] at edge %0d: got %0h expected known value",
                                 k, e, bus_w[k]);
                    end
                    if (!cur_read[k])
                        chk("wr_data", k, 32'(bus_w[k]), 32'(cur_wdata[k]));
                end else begin
                    chk("ram_rw_idle", k, 32'(ram_rw_w[k]), 32'(1));
                end

                if (done_w[k]) begin
                    if (exp_q[k].size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL done_spurious[%0d] at edge %0d: got 1 expected 0", k, e);
                    end else begin
                        logic [39:0] ent;
                        ent = exp_q[k].pop_front();
                        chk("done_edge", k, 32'(e), ent[39:8]);
                        chk("rdata", k, 32'(rdata_w[k]), 32'(ent[7:0]));
                    end
                end else if (exp_q[k].size() != 0 && int'(exp_q[k][0][39:8]) <= e) begin
                    void'(exp_q[k].pop_front());
                    checks++;
                    failures++;
                    $display("FAIL done_missing[%0d] at edge %0d: got 0 expected 1", k, e);
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic issue(input bit rw, input logic [7:0] a, input logic [7:0] d);
        int n;
        n = 0;
        @(negedge clk);
        while (!(edge_cnt + 1 >= nf[0] && edge_cnt + 1 >= nf[1]) && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) begin
            checks++;
            failures++;
            $display("FAIL issue_timeout[0] at edge %0d: got busy expected idle", edge_cnt);
        end
        req       = 1'b1;
        req_rw    = rw;
        req_addr  = a;
        req_wdata = d;
        @(negedge clk);
        // Scramble inputs after the accept edge; they must not matter.
        req       = 1'b0;
        req_rw    = 1'($urandom_range(0, 1));
        req_addr  = 8'($urandom_range(0, 255));
        req_wdata = 8'($urandom_range(0, 255));
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        #3 clr = 1'b0;
        #4;
        for (int k = 0; k < 2; k++) begin
            chk("rst_ce", k, 32'(ram_ce_w[k]), 32'(0));
            chk("rst_rw", k, 32'(ram_rw_w[k]), 32'(1));
            chk("rst_addr", k, 32'(ram_addr_w[k]), 32'(0));
            chk("rst_busy", k, 32'(busy_w[k]), 32'(0));
            chk("rst_done", k, 32'(done_w[k]), 32'(0));
            chk("rst_rdata", k, 32'(rdata_w[k]), 32'(0));
        end
        idle_cycles(2);
        clr = 1'b1;
        idle_cycles(2);

        // Write then read back the same word.
        issue(1'b0, 8'h3C, 8'hA5);
        issue(1'b1, 8'h3C, 8'h00);

        // read_wait boundary on the preloaded word.
        issue(1'b1, 8'h80, 8'h00);

        // A write request during a read is dropped; the word stays intact.
        issue(1'b1, 8'h01, 8'h00);
        req = 1'b1; req_rw = 1'b0; req_addr = 8'h01; req_wdata = 8'hFF;
        @(negedge clk);
        req = 1'b0;
        issue(1'b1, 8'h01, 8'h00);

        // Continuous req: alternate write 00 -> FF and read FF, paced by the
        // faster instance; the slower one picks up whatever is presented.
        issue(1'b1, 8'h00, 8'h00);
        while (!(edge_cnt + 1 >= nf[0] && edge_cnt + 1 >= nf[1])) @(negedge clk);
        req = 1'b1; req_rw = 1'b0; req_addr = 8'hFF; req_wdata = 8'h00;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (edge_cnt + 1 >= nf[1]) req_rw = ~req_rw;
        end
        req = 1'b0;

        // Reset in the second READ cycle abandons the access.
        issue(1'b1, 8'h10, 8'h00);
        begin
            int acc;
            int n;
            acc = cur_acc[0];
            n = 0;
            do begin
                @(posedge clk);
                #2;
                n++;
            end while (edge_cnt < acc + 1 && n < 20);
        end
        clr = 1'b0;
        #1;
        for (int k = 0; k < 2; k++) begin
            chk("mid_rst_ce", k, 32'(ram_ce_w[k]), 32'(0));
            chk("mid_rst_rw", k, 32'(ram_rw_w[k]), 32'(1));
            chk("mid_rst_busy", k, 32'(busy_w[k]), 32'(0));
            chk("mid_rst_done", k, 32'(done_w[k]), 32'(0));
            chk("mid_rst_rdata", k, 32'(rdata_w[k]), 32'(0));
        end
        model_reset();
        @(negedge clk);
        clr = 1'b1;
        idle_cycles(5);
        issue(1'b1, 8'h3C, 8'h00);

        // Randomized traffic: orderly requests plus raw pulses that may land
        // while busy.
        for (int i = 0; i < 150; i++) begin
            logic [7:0] a;
            a = ($urandom_range(0, 3) != 0) ? 8'($urandom_range(0, 15))
                                            : 8'($urandom_range(0, 255));
            if ($urandom_range(0, 2) != 0) begin
                issue(1'($urandom_range(0, 1)), a, 8'($urandom_range(0, 255)));
            end else begin
                req = 1'b1; req_rw = 1'($urandom_range(0, 1));
                req_addr = a; req_wdata = 8'($urandom_range(0, 255));
                idle_cycles($urandom_range(1, 3));
                req = 1'b0;
                idle_cycles($urandom_range(0, 2));
            end
        end

        idle_cycles(20);
        for (int k = 0; k < 2; k++)
            chk("drain", k, 32'(exp_q[k].size()), 32'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ram_master.md
Name: ram_master

Overview:
- Initiator-side controller that drives the parameterised register RAM's bus: address, chip enable, read/write strobe and the shared bidirectional data bus.
- Takes single-word read/write requests from the cache over a req/done handshake.
- Inserts a programmable read wait-state count to model slow RAM access.
- Sits between the cache controller and the RAM instance.

Parameters:
- d_width, 8, data bus width in bits
- a_width, 8, address width (2**a_width words)
- read_wait, 4, cycles ram_ce/ram_rw are held for a read before capture; legal range 2..255

Ports:
- clk  input  1  posedge clock
- clr  input  1  asynchronous active-low reset
- req  input  1  request strobe; sampled only in IDLE
- req_rw  input  1  1 = read, 0 = write
- req_addr  input  a_width  request address
- req_wdata  input  d_width  write data
- busy  output  1  high whenever state is not IDLE
- done  output  1  one-cycle completion pulse
- rdata  output  d_width  last read result; holds until next read completes
- ram_addr  output  a_width  RAM address
- ram_ce  output  1  RAM chip enable
- ram_rw  output  1  RAM strobe; 1 = read, 0 = write
- ram_data  inout  d_width  shared RAM data bus

Behaviour:
- Reset (clr low, asynchronous, any state):
  - state = IDLE
  - ram_ce = 0, ram_rw = 1, ram_addr = 0, bus released (all Z)
  - busy = 0, done = 0, rdata = 0, wait counter = 0
  - An access in flight is abandoned; no partial write is issued after reset.
- All outputs are registered. The ram_data driver is the only combinational output.
- Bus ownership:
  - ram_data is driven with the latched write data only while state == WRITE; otherwise it is Z.
  - In WRITE, ram_rw = 0, so the RAM's output buffer is off and there is no contention.
- States:
  - IDLE -> WRITE or READ. On an edge with req = 1, latch req_addr, req_rw and req_wdata, then:
    - write: set ram_addr, ram_ce = 1, ram_rw = 0; go to WRITE.
    - read: set ram_addr, ram_ce = 1, ram_rw = 1, counter = read_wait - 1; go to READ.
  - WRITE: exactly one cycle with ce = 1, rw = 0 and data driven; the RAM stores the word on the closing edge. At that edge: ram_ce = 0, ram_rw = 1, done = 1, go to DONE.
  - READ: ce = 1, rw = 1 held; the RAM's output register loads on the first edge.
    - Each edge with counter != 0: decrement counter.
    - Edge with counter == 0: rdata <= ram_data, ram_ce = 0, done = 1, go to DONE.
  - DONE: one cycle with done = 1, busy = 1. Next edge: done = 0, go to IDLE.
- Latency, counted from the accepting edge:
  - write: done high in cycle 2.
  - read: done high in cycle read_wait + 1.
  - Minimum request spacing: write 3 cycles, read read_wait + 2 cycles.
- Boundary conditions:
  - req while busy: ignored, not queued.
  - req held high continuously: a new access starts in every IDLE cycle.
  - Input changes after the accept edge have no effect.
  - Address wrap: none; ram_addr is the latched address verbatim, including all-ones.
  - A read in which the RAM never drives (e.g. the RAM is held in clear) captures whatever the bus shows; no detection is required.

Decomposition:
- Shared package ram_master_pkg:
  - state encoding (IDLE, WRITE, READ, DONE as 2-bit constants)
  - RW_READ = 1, RW_WRITE = 0
  - bus-release constant
- One sub-module, wait_counter: a loadable down-counter (8 bits) with load, dec and zero outputs, reused by the cache for its own timing.

Test Plan:
- Reset mid-read: start read at addr 8'h10, assert clr low in the second READ cycle -> immediately ce = 0, rw = 1, bus Z, busy = 0, done = 0. After release, no access occurs until the next req.
- Write then read: write 8'hA5 to 8'h3C, then read 8'h3C with read_wait = 4 -> done in cycle 2 after the write accept, done in cycle 5 after the read accept, rdata = 8'hA5.
- Bus contention: over a write/read/write sequence, ram_data is never driven by both ends. The bench checks for no X on the bus while ce = 1, and Z from the master in READ.
- req while busy: pulse req (write 8'hFF to 8'h01) during a READ -> ignored; RAM[8'h01] unchanged; exactly one done pulse.
- Continuous req, alternating write 8'h00→addr 8'hFF and read addr 8'hFF with read_wait = 2 -> spacing is exactly 3 and 4 cycles; read returns 8'h00; address all-ones is handled.
- read_wait = 2 boundary: RAM pre-loaded with 8'h5A at 8'h80 -> read captures 8'h5A; done in cycle 3 after accept.
